// File: rtl/hpdcache_wbuf_flush_sched.sv
// Send scheduler for the HPDcache write buffer: ages open directory entries,
// flags entries that must go to the NoC (age threshold, full, global flush)
// and issues one registered valid/ready send request at a time, chosen
// round-robin among the eligible entries.
module hpdcache_wbuf_flush_sched #(
  parameter int unsigned WBUF_DIR_ENTRIES   = 8,
  parameter int unsigned WBUF_TIMECNT_WIDTH = 3,
  localparam int unsigned IDX_W = $clog2(WBUF_DIR_ENTRIES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [WBUF_TIMECNT_WIDTH-1:0] cfg_threshold_i,
  input  logic                          cfg_rst_on_write_i,
  input  logic                          flush_all_i,
  input  logic [WBUF_DIR_ENTRIES-1:0]   entry_open_i,
  input  logic [WBUF_DIR_ENTRIES-1:0]   entry_write_i,
  input  logic [WBUF_DIR_ENTRIES-1:0]   entry_full_i,
  output logic                          send_valid_o,
  output logic [IDX_W-1:0]              send_idx_o,
  input  logic                          send_ready_i,
  output logic                          flush_busy_o
);

  localparam int unsigned N = WBUF_DIR_ENTRIES;
  localparam int unsigned W = WBUF_TIMECNT_WIDTH;
  localparam logic [W-1:0] AGE_MAX = {W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [N-1:0][W-1:0]   age_q, age_d;
  logic [N-1:0]          snap_q, snap_d;
  logic [N-1:0]          mask_q, mask_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      send_idx_q, send_idx_d;
  logic                  send_valid_q, send_valid_d;
  logic                  flush_busy_q, flush_busy_d;

  logic [N-1:0]          elig_s;
  logic                  found_s;
  logic [IDX_W-1:0]      win_s;
  logic [IDX_W-1:0]      cand_s;
  logic                  hs_s;
  logic [N-1:0]          hs_vec_s;

  // Per-entry saturating age: cleared when closed or (optionally) written.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      if (!entry_open_i[i]) begin
        age_d[i] = {W{1'b0}};
      end else if (entry_write_i[i] && cfg_rst_on_write_i) begin
        age_d[i] = {W{1'b0}};
      end else if (age_q[i] == AGE_MAX) begin
        age_d[i] = AGE_MAX;
      end else begin
        age_d[i] = age_q[i] + {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Eligibility: open, not already sent, and old enough, full or flushed.
  always_comb begin
    elig_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      elig_s[i] = entry_open_i[i] & ~mask_q[i] &
                  ((age_q[i] >= cfg_threshold_i) | entry_full_i[i] | snap_q[i]);
    end
  end

  // Round-robin pick: first eligible index at or after the rr pointer.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      cand_s = rr_q + IDX_W'(k);
      if (!found_s && elig_s[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Send FSM: register the winner in IDLE, hold it in REQ until accepted or closed.
  always_comb begin
    state_d    = state_q;
    send_idx_d = send_idx_q;
    rr_d       = rr_q;
    hs_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d    = ST_REQ;
          send_idx_d = win_s;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (send_ready_i) begin
          // Handshake takes precedence over a same-cycle close.
          hs_s    = 1'b1;
          state_d = ST_IDLE;
          rr_d    = send_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else if (!entry_open_i[send_idx_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    send_valid_d = (state_d == ST_REQ);
  end

  // Sent-mask and flush snapshot bookkeeping.
  always_comb begin
    hs_vec_s = {N{1'b0}};
    if (hs_s) begin
      hs_vec_s[send_idx_q] = 1'b1;
    end else begin
      hs_vec_s = {N{1'b0}};
    end
    // Mask holds off re-issue until the WBUF reports the entry closed.
    mask_d = (mask_q & entry_open_i) | hs_vec_s;
    if (flush_all_i) begin
      snap_d = (snap_q | entry_open_i) & entry_open_i & ~hs_vec_s;
    end else begin
      snap_d = snap_q & entry_open_i & ~hs_vec_s;
    end
    flush_busy_d = |snap_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      age_q        <= {(N*W){1'b0}};
      snap_q       <= {N{1'b0}};
      mask_q       <= {N{1'b0}};
      rr_q         <= {IDX_W{1'b0}};
      send_idx_q   <= {IDX_W{1'b0}};
      send_valid_q <= 1'b0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      age_q        <= age_d;
      snap_q       <= snap_d;
      mask_q       <= mask_d;
      rr_q         <= rr_d;
      send_idx_q   <= send_idx_d;
      send_valid_q <= send_valid_d;
      flush_busy_q <= flush_busy_d;
    end
  end

  assign send_valid_o = send_valid_q;
  assign send_idx_o   = send_idx_q;
  assign flush_busy_o = flush_busy_q;

endmodule
